riscv_core_scoreboard_nw: RTL and testbench
===========================================

Name: riscv_core_scoreboard_nw

Overview:
- Parametrised N-wide issue scoreboard for the out-of-order-issue / in-order-commit RISC-V core. It replaces the fixed 2-wide scoreboard.
- Tracks each ROB slot: pending/finished status, owning lane, current pipeline stage, and result-valid stage.
- Produces per-source bypass selects, per-source and per-slot ready bits, and a pending-entry count.
- Adds two behaviours the fixed version lacks: per-issue result latency, and a full ROB flush.
- Sits beside the issue queue in D; consumes lane stall vectors from X0..W and commit/flush from the ROB.

Parameters:
- NSLOTS, 32, number of ROB slots tracked; SLOT_W = clog2(NSLOTS).
- WIDTH, 2, issue lanes.
- NCOMMIT, 2, ROB commit ports.
- DEPTH, 5, stages per lane (X0..X(DEPTH-2), W); STG_W = clog2(DEPTH+1).
- SEL_W, clog2(WIDTH*DEPTH+2), bypass select width (4 at defaults).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- iss_val  in  WIDTH  lane i issues this cycle
- iss_rd_en  in  WIDTH  lane i instruction writes a result
- iss_rd  in  WIDTH*SLOT_W  destination ROB slot per lane
- iss_lat  in  WIDTH*STG_W  stage index (0..DEPTH-1) at which lane i result becomes bypassable
- src_tag  in  WIDTH*2*SLOT_W  source tags; index = lane*2+src
- src_ren  in  WIDTH*2  source is renamed to a ROB slot
- stall  in  WIDTH*DEPTH  per-lane per-stage stall; bit lane*DEPTH+stage
- cmt_val  in  NCOMMIT  commit port valid
- cmt_slot  in  NCOMMIT*SLOT_W  committed slot
- flush  in  1  squash all in-flight entries
- byp_sel  out  WIDTH*2*SEL_W  bypass select per source
- op_ready  out  WIDTH*2  source operand available
- slot_ready  out  NSLOTS  per-slot ready vector
- pending_cnt  out  clog2(NSLOTS+1)  number of pending slots

Behaviour:
- Per-slot state (registered):
  - pend: 1 bit.
  - lane: clog2(WIDTH) bits.
  - stg: STG_W bits; 0..DEPTH-1 = in lane stage, DEPTH = written to ROB.
  - lat: STG_W bits.
- Reset (reset_n=0 at posedge):
  - all pend=0, stg=DEPTH, lane=0, lat=0, pending_cnt=0.
  - Outputs then: byp_sel=0, op_ready all 1, slot_ready all 1.
  - Reset mid-operation discards all state the same way.
- Issue: for lane i with iss_val&iss_rd_en, slot iss_rd[i] gets pend=1, lane=i, stg=0, lat=iss_lat[i] next cycle.
  - If two lanes name the same slot, the lowest lane index wins.
  - Issue to a slot that is committing in the same cycle: issue wins, and pend stays 1.
- Advance: for a non-issued pending slot with stg<DEPTH:
  - stg holds if stall[lane*DEPTH+stg]=1, else stg+1.
  - The stg=DEPTH-1 (W) to DEPTH transition obeys the same rule.
  - Once at DEPTH, the slot holds at DEPTH.
- Commit: any cmt_val[k] with cmt_slot[k]==s clears pend[s] (unless s is issued that cycle). Duplicate commit of the same slot counts once.
- Flush: all pend=0, stg=DEPTH next cycle. Issues and commits in the flush cycle are ignored; pending_cnt=0.
- pending_cnt: registered; equals the popcount of pend after every update. Never exceeds NSLOTS and never underflows.
- Bypass select per source (combinational from current state):
  - src_ren=0 or pend=0 -> 0 (register file).
  - pend, stg<DEPTH, stg>=lat -> 1+lane*DEPTH+stg.
  - pend, stg==DEPTH -> WIDTH*DEPTH+1 (ROB).
  - pend, stg<lat -> 0, and op_ready=0.
  - Default encoding: lane0 X0..W = 1..5, lane1 X0..W = 6..10, ROB = 11.
- op_ready = ~src_ren | ~pend | (stg>=lat). slot_ready[s] uses the same formula with src_ren=1.
- Sources read state before the same-cycle issue. A source naming a slot issued this cycle sees the old state; the issue queue is responsible for not issuing such a dependent in the same cycle.

Test Plan:
- Reset: reset_n=0 two cycles with random inputs -> pending_cnt=0, byp_sel=0, slot_ready=all 1.
- Lane0 issue rd=7, lat=2, no stalls; lane1 src tag 7 renamed:
  - cycles 1,2: op_ready=0.
  - cycle 3: byp_sel=3 (X2).
  - cycle 4: byp_sel=4; cycle 5: byp_sel=5.
  - cycle 6: byp_sel=11 until commit of slot 7, then 0 with pending_cnt back to 0.
- Lane1 issue rd=3, lat=0, stall X0 held 3 cycles -> byp_sel=6 for 4 cycles, then 7.
- Both lanes issue rd=9 same cycle, lane0 lat=4, lane1 lat=0 -> lane0 wins; byp_sel stays 0 with op_ready=0 until stg=4 (byp_sel=5); pending_cnt=1.
- Commit slot 5 and issue slot 5 same cycle -> pend[5]=1, stg=0; pending_cnt unchanged.
- Issue 10 slots, commit 2, assert flush together with a new issue -> next cycle pending_cnt=0, all slot_ready=1, new issue dropped.

Source files
------------

// File: rtl/riscv_core_scoreboard_nw_if.sv
// Issue/commit/bypass bundle between the issue queue, the ROB and the N-wide scoreboard.
interface riscv_core_scoreboard_nw_if #(
  parameter int NSLOTS  = 32,
  parameter int WIDTH   = 2,
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 5
);
  localparam int SLOT_W = $clog2(NSLOTS);
  localparam int STG_W  = $clog2(DEPTH + 1);
  localparam int SEL_W  = $clog2(WIDTH * DEPTH + 2);
  localparam int CNT_W  = $clog2(NSLOTS + 1);

  logic [WIDTH-1:0]           iss_val;
  logic [WIDTH-1:0]           iss_rd_en;
  logic [WIDTH*SLOT_W-1:0]    iss_rd;
  logic [WIDTH*STG_W-1:0]     iss_lat;
  logic [WIDTH*2*SLOT_W-1:0]  src_tag;
  logic [WIDTH*2-1:0]         src_ren;
  logic [WIDTH*DEPTH-1:0]     stall;
  logic [NCOMMIT-1:0]         cmt_val;
  logic [NCOMMIT*SLOT_W-1:0]  cmt_slot;
  logic                       flush;
  logic [WIDTH*2*SEL_W-1:0]   byp_sel;
  logic [WIDTH*2-1:0]         op_ready;
  logic [NSLOTS-1:0]          slot_ready;
  logic [CNT_W-1:0]           pending_cnt;

  modport master (
    output iss_val, iss_rd_en, iss_rd, iss_lat, src_tag, src_ren, stall,
           cmt_val, cmt_slot, flush,
    input  byp_sel, op_ready, slot_ready, pending_cnt
  );

  modport slave (
    input  iss_val, iss_rd_en, iss_rd, iss_lat, src_tag, src_ren, stall,
           cmt_val, cmt_slot, flush,
    output byp_sel, op_ready, slot_ready, pending_cnt
  );
endinterface

// File: rtl/riscv_core_scoreboard_nw.sv
// N-wide issue scoreboard: tracks every ROB slot's pending state, owning lane and
// pipeline stage, and derives bypass selects and operand-ready bits from it.
module riscv_core_scoreboard_nw #(
  parameter int NSLOTS  = 32,
  parameter int WIDTH   = 2,
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  riscv_core_scoreboard_nw_if.slave   sb
);
  localparam int SLOT_W = $clog2(NSLOTS);
  localparam int STG_W  = $clog2(DEPTH + 1);
  localparam int SEL_W  = $clog2(WIDTH * DEPTH + 2);
  localparam int CNT_W  = $clog2(NSLOTS + 1);
  localparam int LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [STG_W-1:0] STG_DONE = STG_W'(DEPTH);

  logic              r_pend [NSLOTS];
  logic [LANE_W-1:0] r_lane [NSLOTS];
  logic [STG_W-1:0]  r_stg  [NSLOTS];
  logic [STG_W-1:0]  r_lat  [NSLOTS];
  logic [CNT_W-1:0]  r_pendCnt;

  logic [NSLOTS-1:0] w_issHit;
  logic [LANE_W-1:0] w_issLane [NSLOTS];
  logic [STG_W-1:0]  w_issLat  [NSLOTS];
  logic [NSLOTS-1:0] w_cmtHit;
  logic [NSLOTS-1:0] w_stallHit;

  logic              w_pendNext [NSLOTS];
  logic [LANE_W-1:0] w_laneNext [NSLOTS];
  logic [STG_W-1:0]  w_stgNext  [NSLOTS];
  logic [STG_W-1:0]  w_latNext  [NSLOTS];
  logic [CNT_W-1:0]  w_cntNext;

  // A source is usable once its producer has reached the stage named by its latency.
  function automatic logic isReady(input logic pend, input logic [STG_W-1:0] stg,
                                   input logic [STG_W-1:0] lat);
    return !pend || (stg >= lat);
  endfunction

  // Bypass encoding: 0 = register file, 1.. = lane stage, last = ROB.
  function automatic logic [SEL_W-1:0] bypFor(input logic pend, input logic [LANE_W-1:0] lane,
                                              input logic [STG_W-1:0] stg,
                                              input logic [STG_W-1:0] lat);
    if (!pend || (stg < lat)) return '0;
    if (stg == STG_DONE) return SEL_W'(WIDTH * DEPTH + 1);
    return SEL_W'(1 + int'(lane) * DEPTH + int'(stg));
  endfunction

  // Decode issue, commit and per-slot stall hits; lanes are scanned high to low so the lowest lane wins.
  always_comb begin
    w_issHit   = '0;
    w_cmtHit   = '0;
    w_stallHit = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      w_issLane[s] = '0;
      w_issLat[s]  = '0;
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (sb.iss_val[i] && sb.iss_rd_en[i]) begin
        w_issHit[sb.iss_rd[i*SLOT_W +: SLOT_W]]  = 1'b1;
        w_issLane[sb.iss_rd[i*SLOT_W +: SLOT_W]] = LANE_W'(i);
        w_issLat[sb.iss_rd[i*SLOT_W +: SLOT_W]]  = sb.iss_lat[i*STG_W +: STG_W];
      end
    end
    for (int k = 0; k < NCOMMIT; k++) begin
      if (sb.cmt_val[k]) w_cmtHit[sb.cmt_slot[k*SLOT_W +: SLOT_W]] = 1'b1;
    end
    for (int s = 0; s < NSLOTS; s++) begin
      for (int l = 0; l < WIDTH; l++) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (r_lane[s] == LANE_W'(l) && r_stg[s] == STG_W'(d) && sb.stall[l*DEPTH+d])
            w_stallHit[s] = 1'b1;
        end
      end
    end
  end

  // Next per-slot state: flush beats issue, issue beats commit, otherwise advance unless stalled.
  always_comb begin
    w_cntNext = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      w_pendNext[s] = r_pend[s];
      w_laneNext[s] = r_lane[s];
      w_stgNext[s]  = r_stg[s];
      w_latNext[s]  = r_lat[s];
      if (sb.flush) begin
        w_pendNext[s] = 1'b0;
        w_stgNext[s]  = STG_DONE;
      end else if (w_issHit[s]) begin
        w_pendNext[s] = 1'b1;
        w_laneNext[s] = w_issLane[s];
        w_stgNext[s]  = '0;
        w_latNext[s]  = w_issLat[s];
      end else begin
        if (w_cmtHit[s]) w_pendNext[s] = 1'b0;
        if (r_pend[s] && (r_stg[s] < STG_DONE) && !w_stallHit[s])
          w_stgNext[s] = r_stg[s] + 1'b1;
      end
      w_cntNext = w_cntNext + CNT_W'(w_pendNext[s]);
    end
  end

  // Register slot state and the pending count, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NSLOTS; s++) begin
        r_pend[s] <= 1'b0;
        r_lane[s] <= '0;
        r_stg[s]  <= STG_DONE;
        r_lat[s]  <= '0;
      end
      r_pendCnt <= '0;
    end else begin
      for (int s = 0; s < NSLOTS; s++) begin
        r_pend[s] <= w_pendNext[s];
        r_lane[s] <= w_laneNext[s];
        r_stg[s]  <= w_stgNext[s];
        r_lat[s]  <= w_latNext[s];
      end
      r_pendCnt <= w_cntNext;
    end
  end

  for (genvar q = 0; q < WIDTH * 2; q++) begin : g_src
    logic [SLOT_W-1:0] w_tag;
    assign w_tag = sb.src_tag[q*SLOT_W +: SLOT_W];
    assign sb.byp_sel[q*SEL_W +: SEL_W] = sb.src_ren[q] ?
        bypFor(r_pend[w_tag], r_lane[w_tag], r_stg[w_tag], r_lat[w_tag]) : '0;
    assign sb.op_ready[q] = !sb.src_ren[q] || isReady(r_pend[w_tag], r_stg[w_tag], r_lat[w_tag]);
  end

  for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
    assign sb.slot_ready[s] = isReady(r_pend[s], r_stg[s], r_lat[s]);
  end

  assign sb.pending_cnt = r_pendCnt;
endmodule

// File: tb/tb_riscv_core_scoreboard_nw.sv
// Directed bench for the N-wide scoreboard at default parameters.
module tb_riscv_core_scoreboard_nw;
  localparam int NSLOTS  = 32;
  localparam int WIDTH   = 2;
  localparam int NCOMMIT = 2;
  localparam int DEPTH   = 5;
  localparam int SLOT_W  = 5;
  localparam int STG_W   = 3;
  localparam int SEL_W   = 4;

  logic clk = 1'b0;
  logic resetN;
  int checkCount = 0;
  int errorCount = 0;

  riscv_core_scoreboard_nw_if #(
    .NSLOTS(NSLOTS), .WIDTH(WIDTH), .NCOMMIT(NCOMMIT), .DEPTH(DEPTH)
  ) bus ();

  riscv_core_scoreboard_nw #(
    .NSLOTS(NSLOTS), .WIDTH(WIDTH), .NCOMMIT(NCOMMIT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(resetN),
    .sb(bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] bypOf(input int idx);
    return 32'(bus.byp_sel[idx*SEL_W +: SEL_W]);
  endfunction

  function automatic logic [31:0] rdyOf(input int idx);
    return 32'(bus.op_ready[idx]);
  endfunction

  function automatic logic [31:0] slotRdy(input int s);
    return 32'(bus.slot_ready[s]);
  endfunction

  function automatic logic [31:0] cntOf();
    return 32'(bus.pending_cnt);
  endfunction

  task automatic clearInputs();
    bus.iss_val   = '0;
    bus.iss_rd_en = '0;
    bus.iss_rd    = '0;
    bus.iss_lat   = '0;
    bus.src_tag   = '0;
    bus.src_ren   = '0;
    bus.stall     = '0;
    bus.cmt_val   = '0;
    bus.cmt_slot  = '0;
    bus.flush     = 1'b0;
  endtask

  // Clock the staged inputs in, then drop the one-shot issue/commit/flush controls.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    bus.iss_val   = '0;
    bus.iss_rd_en = '0;
    bus.cmt_val   = '0;
    bus.flush     = 1'b0;
    #1;
  endtask

  task automatic stageIssue(input int lane, input int rd, input int lat);
    bus.iss_val[lane]   = 1'b1;
    bus.iss_rd_en[lane] = 1'b1;
    bus.iss_rd[lane*SLOT_W +: SLOT_W] = SLOT_W'(rd);
    bus.iss_lat[lane*STG_W +: STG_W]  = STG_W'(lat);
  endtask

  task automatic stageCommit(input int port, input int slot);
    bus.cmt_val[port] = 1'b1;
    bus.cmt_slot[port*SLOT_W +: SLOT_W] = SLOT_W'(slot);
  endtask

  task automatic watchSrc(input int idx, input int tag);
    bus.src_tag[idx*SLOT_W +: SLOT_W] = SLOT_W'(tag);
    bus.src_ren[idx] = 1'b1;
    #1;
  endtask

  initial begin
    clearInputs();
    resetN = 1'b0;

    // Reset held two cycles while the inputs toggle randomly.
    repeat (2) begin
      bus.iss_val   = 2'($urandom);
      bus.iss_rd_en = 2'($urandom);
      bus.iss_rd    = 10'($urandom);
      bus.iss_lat   = 6'($urandom);
      bus.src_tag   = 20'($urandom);
      bus.src_ren   = 4'($urandom) | 4'b0001;
      bus.stall     = 10'($urandom);
      bus.cmt_val   = 2'($urandom);
      bus.cmt_slot  = 10'($urandom);
      bus.flush     = 1'($urandom);
      @(posedge clk);
    end
    #1;
    checkOutput("rst_cnt", cntOf(), 0);
    checkOutput("rst_byp", 32'(bus.byp_sel), 0);
    checkOutput("rst_oprdy", 32'(bus.op_ready), 32'hF);
    checkOutput("rst_slotrdy", 32'(bus.slot_ready), 32'hFFFF_FFFF);
    clearInputs();
    resetN = 1'b1;
    applyStimulus();

    // Lane0 writes slot 7 with latency 2; lane1 src0 depends on it.
    watchSrc(2, 7);
    stageIssue(0, 7, 2);
    applyStimulus();
    checkOutput("lat2_c1_rdy", rdyOf(2), 0);
    checkOutput("lat2_c1_byp", bypOf(2), 0);
    checkOutput("lat2_c1_cnt", cntOf(), 1);
    checkOutput("lat2_c1_slot7", slotRdy(7), 0);
    applyStimulus();
    checkOutput("lat2_c2_rdy", rdyOf(2), 0);
    applyStimulus();
    checkOutput("lat2_c3_byp", bypOf(2), 3);
    checkOutput("lat2_c3_rdy", rdyOf(2), 1);
    applyStimulus();
    checkOutput("lat2_c4_byp", bypOf(2), 4);
    applyStimulus();
    checkOutput("lat2_c5_byp", bypOf(2), 5);
    applyStimulus();
    checkOutput("lat2_c6_rob", bypOf(2), 11);
    applyStimulus();
    checkOutput("lat2_c7_rob", bypOf(2), 11);
    stageCommit(1, 7);
    applyStimulus();
    checkOutput("cmt7_byp", bypOf(2), 0);
    checkOutput("cmt7_cnt", cntOf(), 0);
    checkOutput("cmt7_slot7", slotRdy(7), 1);

    // Lane1 slot 3, latency 0, X0 stalled for three edges.
    watchSrc(2, 3);
    bus.stall[1*DEPTH+0] = 1'b1;
    stageIssue(1, 3, 0);
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall_x0_%0d", i), bypOf(2), 6);
      if (i == 3) bus.stall[1*DEPTH+0] = 1'b0;
      applyStimulus();
    end
    checkOutput("stall_rel_x1", bypOf(2), 7);
    applyStimulus();
    checkOutput("stall_rel_x2", bypOf(2), 8);
    stageCommit(0, 3);
    stageCommit(1, 3);
    applyStimulus();
    checkOutput("dupcmt_cnt", cntOf(), 0);

    // Both lanes name slot 9; lane0 (latency 4) must win over lane1 (latency 0).
    watchSrc(2, 9);
    stageIssue(0, 9, 4);
    stageIssue(1, 9, 0);
    applyStimulus();
    checkOutput("same_rd_cnt", cntOf(), 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("same_rd_byp_s%0d", i), bypOf(2), 0);
      checkOutput($sformatf("same_rd_rdy_s%0d", i), rdyOf(2), 0);
      applyStimulus();
    end
    checkOutput("same_rd_byp_s4", bypOf(2), 5);
    checkOutput("same_rd_rdy_s4", rdyOf(2), 1);

    // Slot 5 re-issued in the same cycle it commits.
    watchSrc(1, 5);
    stageIssue(0, 5, 0);
    applyStimulus();
    checkOutput("s5_issue_byp", bypOf(1), 1);
    checkOutput("s5_issue_cnt", cntOf(), 2);
    applyStimulus();
    checkOutput("s5_x1_byp", bypOf(1), 2);
    applyStimulus();
    checkOutput("s5_x2_byp", bypOf(1), 3);
    stageIssue(0, 5, 0);
    stageCommit(0, 5);
    applyStimulus();
    checkOutput("s5_reissue_byp", bypOf(1), 1);
    checkOutput("s5_reissue_cnt", cntOf(), 2);
    checkOutput("s9_rob_hold", bypOf(2), 11);

    // Fill ten slots, retire two, then flush alongside a new issue and a commit.
    for (int k = 0; k < 5; k++) begin
      stageIssue(0, 10 + 2 * k, 3);
      stageIssue(1, 11 + 2 * k, 3);
      applyStimulus();
    end
    checkOutput("fill_cnt", cntOf(), 12);
    stageCommit(0, 10);
    stageCommit(1, 11);
    applyStimulus();
    checkOutput("fill_cmt_cnt", cntOf(), 10);
    checkOutput("fill_slot19", slotRdy(19), 0);
    watchSrc(2, 25);
    bus.flush = 1'b1;
    stageIssue(0, 25, 3);
    stageCommit(0, 12);
    applyStimulus();
    checkOutput("flush_cnt", cntOf(), 0);
    checkOutput("flush_slotrdy", 32'(bus.slot_ready), 32'hFFFF_FFFF);
    checkOutput("flush_drop_byp", bypOf(2), 0);
    checkOutput("flush_drop_rdy", rdyOf(2), 1);
    checkOutput("flush_s5_byp", bypOf(1), 0);
    stageIssue(0, 25, 3);
    applyStimulus();
    checkOutput("post_flush_rdy", rdyOf(2), 0);
    checkOutput("post_flush_cnt", cntOf(), 1);

    // Reset in the middle of traffic discards everything.
    stageIssue(1, 30, 2);
    applyStimulus();
    checkOutput("pre_rst_cnt", cntOf(), 2);
    resetN = 1'b0;
    applyStimulus();
    checkOutput("mid_rst_cnt", cntOf(), 0);
    checkOutput("mid_rst_slotrdy", 32'(bus.slot_ready), 32'hFFFF_FFFF);
    checkOutput("mid_rst_rdy", rdyOf(2), 1);
    resetN = 1'b1;
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
